// File: rtl/event_rr_dispatch.sv
// Round-robin event dispatcher: steers single-cycle events to N_CH lanes, skipping busy lanes.
// Define EVT_RR_STRICT_EN for strict rotation (no skipping; a busy target lane drops the event).
module event_rr_dispatch #(
    parameter int N_CH = 2,
    parameter int DW   = 16,
    parameter int CW   = ($clog2(N_CH) > 0) ? $clog2(N_CH) : 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in_valid,
    input  logic [DW-1:0]        in_data,
    output logic                 in_ready,
    input  logic [N_CH-1:0]      ch_ready,
    output logic [N_CH-1:0]      out_valid,
    output logic [N_CH*DW-1:0]   out_data,
    output logic [CW-1:0]        cur_ch,
    output logic [15:0]          drop_cnt
);

    logic [CW-1:0]        ptr_q, ptr_d;
    logic [N_CH-1:0]      valid_q, valid_d;
    logic [N_CH*DW-1:0]   data_q, data_d;
    logic [15:0]          drop_q, drop_d;

    logic [N_CH-1:0]      grant;
    logic [CW-1:0]        sel;
    logic                 accept;
    logic                 drop;

`ifdef EVT_RR_STRICT_EN
    // Only the lane under the pointer may take the event.
    for (genvar gi = 0; gi < N_CH; gi++) begin : gen_strict
        assign grant[gi] = ch_ready[gi] & (ptr_q == CW'(gi));
    end
`else
    logic [N_CH-1:0] at_or_after;
    logic [N_CH-1:0] req_hi;
    logic [N_CH-1:0] req_pick;

    for (genvar gi = 0; gi < N_CH; gi++) begin : gen_mask
        assign at_or_after[gi] = (CW'(gi) >= ptr_q);
    end

    // Prefer ready lanes at/after the pointer; otherwise wrap to the lowest ready lane.
    assign req_hi   = ch_ready & at_or_after;
    assign req_pick = (|req_hi) ? req_hi : ch_ready;
    assign grant    = req_pick & (~req_pick + N_CH'(1));
`endif

    // One-hot grant to binary index.
    for (genvar gb = 0; gb < CW; gb++) begin : gen_enc
        logic [N_CH-1:0] plane;
        for (genvar gi = 0; gi < N_CH; gi++) begin : gen_bit
            localparam logic [CW-1:0] IDX = CW'(gi);
            assign plane[gi] = grant[gi] & IDX[gb];
        end
        assign sel[gb] = |plane;
    end

    assign in_ready = |grant;
    assign accept   = in_valid & in_ready;
    assign drop     = in_valid & ~in_ready;

    assign valid_d = accept ? grant : '0;

    for (genvar gi = 0; gi < N_CH; gi++) begin : gen_data
        assign data_d[gi*DW +: DW] = (accept & grant[gi]) ? in_data : '0;
    end

    assign ptr_d  = accept ? ((sel == CW'(N_CH - 1)) ? '0 : sel + CW'(1)) : ptr_q;
    assign drop_d = (drop && (drop_q != 16'hFFFF)) ? drop_q + 16'd1 : drop_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            ptr_q   <= '0;
            valid_q <= '0;
            data_q  <= '0;
            drop_q  <= '0;
        end else begin
            ptr_q   <= ptr_d;
            valid_q <= valid_d;
            data_q  <= data_d;
            drop_q  <= drop_d;
        end
    end

    assign out_valid = valid_q;
    assign out_data  = data_q;
    assign cur_ch    = ptr_q;
    assign drop_cnt  = drop_q;

endmodule

// File: tb/tb_event_rr_dispatch.sv
// Scoreboard bench for event_rr_dispatch: a 2-lane and a 3-lane instance driven by directed vectors.
module tb_event_rr_dispatch;

    typedef struct packed {
        logic [2:0]  v;
        logic [47:0] d;
        logic [1:0]  ch;
        logic [15:0] drop;
    } rec_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // 2-lane instance
    logic        rst2 = 1'b1, v2 = 1'b0;
    logic [15:0] d2 = '0;
    logic [1:0]  rdy2 = '0;
    logic        ir2;
    logic [1:0]  ov2;
    logic [31:0] od2;
    logic [0:0]  cc2;
    logic [15:0] dc2;

    // 3-lane instance
    logic        rst3 = 1'b1, v3 = 1'b0;
    logic [15:0] d3 = '0;
    logic [2:0]  rdy3 = '0;
    logic        ir3;
    logic [2:0]  ov3;
    logic [47:0] od3;
    logic [1:0]  cc3;
    logic [15:0] dc3;

    event_rr_dispatch #(.N_CH(2), .DW(16)) dut2 (
        .clk(clk), .reset(rst2), .in_valid(v2), .in_data(d2), .in_ready(ir2),
        .ch_ready(rdy2), .out_valid(ov2), .out_data(od2), .cur_ch(cc2), .drop_cnt(dc2)
    );

    event_rr_dispatch #(.N_CH(3), .DW(16)) dut3 (
        .clk(clk), .reset(rst3), .in_valid(v3), .in_data(d3), .in_ready(ir3),
        .ch_ready(rdy3), .out_valid(ov3), .out_data(od3), .cur_ch(cc3), .drop_cnt(dc3)
    );

    rec_t q2[$];
    rec_t q3[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   n_rec2 = 0;
    int   n_rec3 = 0;
    bit   mon_en = 1'b0;

    // Monitor: pops one expected record per stimulus cycle, otherwise expects silence.
    initial begin
        rec_t act;
        rec_t exp_r;
        forever begin
            @(posedge clk);
            #1;
            if (mon_en) begin
                act = '{v: {1'b0, ov2}, d: {16'h0, od2}, ch: {1'b0, cc2}, drop: dc2};
                n_cmp++;
                if (q2.size() > 0) begin
                    exp_r = q2.pop_front();
                    n_rec2++;
                    if (act !== exp_r) begin
                        n_bad++;
                        $display("FAIL dut2 rec%0d: got v=%b d=%h ch=%0d drop=%h, want v=%b d=%h ch=%0d drop=%h",
                                 n_rec2, act.v, act.d, act.ch, act.drop, exp_r.v, exp_r.d, exp_r.ch, exp_r.drop);
                    end else begin
                        $display("dut2 rec%0d ok: v=%b d=%h ch=%0d drop=%h", n_rec2, act.v, act.d, act.ch, act.drop);
                    end
                end else if (ov2 !== 2'b00) begin
                    n_bad++;
                    $display("FAIL dut2 idle: got out_valid=%b, want 00", ov2);
                end

                act = '{v: ov3, d: od3, ch: cc3, drop: dc3};
                n_cmp++;
                if (q3.size() > 0) begin
                    exp_r = q3.pop_front();
                    n_rec3++;
                    if (act !== exp_r) begin
                        n_bad++;
                        $display("FAIL dut3 rec%0d: got v=%b d=%h ch=%0d drop=%h, want v=%b d=%h ch=%0d drop=%h",
                                 n_rec3, act.v, act.d, act.ch, act.drop, exp_r.v, exp_r.d, exp_r.ch, exp_r.drop);
                    end else begin
                        $display("dut3 rec%0d ok: v=%b d=%h ch=%0d drop=%h", n_rec3, act.v, act.d, act.ch, act.drop);
                    end
                end else if (ov3 !== 3'b000) begin
                    n_bad++;
                    $display("FAIL dut3 idle: got out_valid=%b, want 000", ov3);
                end
            end
        end
    end

    // One stimulus cycle on instance u (2 or 3); the other instance idles.
    task automatic step(input int u, input logic rst, input logic v, input logic [15:0] d,
                        input logic [2:0] rdy, input logic eir, input logic [2:0] ev,
                        input logic [47:0] ed, input logic [1:0] ech, input logic [15:0] edrop);
        logic act_ir;
        @(negedge clk);
        if (u == 2) begin
            rst2 = rst; v2 = v; d2 = d; rdy2 = rdy[1:0];
            rst3 = 1'b0; v3 = 1'b0;
            q2.push_back('{v: ev, d: ed, ch: ech, drop: edrop});
        end else begin
            rst3 = rst; v3 = v; d3 = d; rdy3 = rdy;
            rst2 = 1'b0; v2 = 1'b0;
            q3.push_back('{v: ev, d: ed, ch: ech, drop: edrop});
        end
        #1;
        act_ir = (u == 2) ? ir2 : ir3;
        n_cmp++;
        if (act_ir !== eir) begin
            n_bad++;
            $display("FAIL in_ready dut%0d: got %b, want %b", u, act_ir, eir);
        end
    endtask

    // Unchecked drops on the 3-lane instance to walk drop_cnt toward saturation.
    task automatic bulk_drop3(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            rst3 = 1'b0; v3 = 1'b1; d3 = 16'h0BAD; rdy3 = 3'b000;
            v2 = 1'b0;
        end
    endtask

    initial begin
        repeat (2) @(negedge clk);
        rst2 = 1'b0; rst3 = 1'b0;
        mon_en = 1'b1;

        // dut2: reset wins over a coincident event
        step(2, 1, 1, 16'h5555, 3'b011, 1, 3'b000, 48'h0, 2'd0, 16'd0);
        // A/B alternation
        step(2, 0, 1, 16'h0001, 3'b011, 1, 3'b001, 48'h0000_0000_0001, 2'd1, 16'd0);
        step(2, 0, 1, 16'h0002, 3'b011, 1, 3'b010, 48'h0000_0002_0000, 2'd0, 16'd0);
        step(2, 0, 1, 16'h0003, 3'b011, 1, 3'b001, 48'h0000_0000_0003, 2'd1, 16'd0);
        step(2, 0, 1, 16'h0004, 3'b011, 1, 3'b010, 48'h0000_0004_0000, 2'd0, 16'd0);
        step(2, 0, 0, 16'h0005, 3'b011, 1, 3'b000, 48'h0, 2'd0, 16'd0);
        // no lane ready: three drops
        step(2, 0, 1, 16'h0006, 3'b000, 0, 3'b000, 48'h0, 2'd0, 16'd1);
        step(2, 0, 1, 16'h0007, 3'b000, 0, 3'b000, 48'h0, 2'd0, 16'd2);
        step(2, 0, 1, 16'h0008, 3'b000, 0, 3'b000, 48'h0, 2'd0, 16'd3);
        step(2, 0, 1, 16'hBEEF, 3'b001, 1, 3'b001, 48'h0000_0000_BEEF, 2'd1, 16'd3);
        step(2, 0, 1, 16'hCAFE, 3'b010, 1, 3'b010, 48'h0000_CAFE_0000, 2'd0, 16'd3);
        step(2, 0, 0, 16'h0000, 3'b011, 1, 3'b000, 48'h0, 2'd0, 16'd3);

        // dut3: rotation with wrap 2 -> 0
        step(3, 0, 1, 16'h0011, 3'b111, 1, 3'b001, 48'h0000_0000_0011, 2'd1, 16'd0);
        step(3, 0, 1, 16'h0022, 3'b111, 1, 3'b010, 48'h0000_0022_0000, 2'd2, 16'd0);
        step(3, 0, 1, 16'h0033, 3'b111, 1, 3'b100, 48'h0033_0000_0000, 2'd0, 16'd0);
        step(3, 0, 1, 16'h0044, 3'b111, 1, 3'b001, 48'h0000_0000_0044, 2'd1, 16'd0);
        // pointer at 1, lane 1 busy
`ifdef EVT_RR_STRICT_EN
        step(3, 0, 1, 16'hAAAA, 3'b101, 0, 3'b000, 48'h0, 2'd1, 16'd1);
`else
        step(3, 0, 1, 16'hAAAA, 3'b101, 1, 3'b100, 48'hAAAA_0000_0000, 2'd0, 16'd0);
`endif
        // reset mid-stream, then first event lands on ch0
        step(3, 1, 1, 16'hFFFF, 3'b111, 1, 3'b000, 48'h0, 2'd0, 16'd0);
        step(3, 0, 1, 16'h0077, 3'b111, 1, 3'b001, 48'h0000_0000_0077, 2'd1, 16'd0);
        // no lane ready: pointer holds, drops counted
        step(3, 0, 1, 16'h0101, 3'b000, 0, 3'b000, 48'h0, 2'd1, 16'd1);
        step(3, 0, 1, 16'h0102, 3'b000, 0, 3'b000, 48'h0, 2'd1, 16'd2);
        step(3, 0, 1, 16'h0103, 3'b000, 0, 3'b000, 48'h0, 2'd1, 16'd3);
        // walk drop_cnt to FFFE, then saturate
        bulk_drop3(65531);
        step(3, 0, 1, 16'h0104, 3'b000, 0, 3'b000, 48'h0, 2'd1, 16'hFFFF);
        step(3, 0, 1, 16'h0105, 3'b000, 0, 3'b000, 48'h0, 2'd1, 16'hFFFF);
        step(3, 0, 1, 16'h0106, 3'b000, 0, 3'b000, 48'h0, 2'd1, 16'hFFFF);
        step(3, 0, 1, 16'h0099, 3'b010, 1, 3'b010, 48'h0000_0099_0000, 2'd2, 16'hFFFF);
        step(3, 0, 0, 16'h0000, 3'b111, 1, 3'b000, 48'h0, 2'd2, 16'hFFFF);

        @(negedge clk);
        v2 = 1'b0; v3 = 1'b0;
        repeat (3) @(negedge clk);
        n_cmp++;
        if (q2.size() != 0 || q3.size() != 0) begin
            n_bad++;
            $display("FAIL scoreboard drain: got %0d/%0d left, want 0/0", q2.size(), q3.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
